// File: rtl/rca_seq_adder_pkg.sv
// rca_seq_adder_pkg: shared FSM encoding, counter sizing and parameter legality for rca_seq_adder
// Contents: state_t (IDLE/RUN/DONE), cnt_w(n) = clog2(n) with a floor of 1,
// legal(w, c) = chunk width divides total width.
package rca_seq_adder_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    function automatic int cnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
    function automatic bit legal(input int w, input int c);
        return c > 0 && w >= c && w % c == 0;
    endfunction
endpackage

// File: rtl/rca_seq_adder_if.sv
// rca_seq_adder_if: operand/result handshake bundle for rca_seq_adder
// Signals: in_valid/in_ready/a/b/ci (request side), out_valid/out_ready/sum/co (result side),
// ovf only when RCA_SEQ_OVF_EN is defined.
// Modports: master = producer/consumer around the adder, slave = the adder itself.
interface rca_seq_adder_if #(parameter int WIDTH = 64);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             co;
`ifdef RCA_SEQ_OVF_EN
    logic             ovf;
`endif
    modport master (
        output in_valid, a, b, ci, out_ready,
        input  in_ready, out_valid, sum, co
`ifdef RCA_SEQ_OVF_EN
        , input ovf
`endif
    );
    modport slave (
        input  in_valid, a, b, ci, out_ready,
        output in_ready, out_valid, sum, co
`ifdef RCA_SEQ_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/rca_seq_adder_nbits.sv
// rca_nbits: combinational BITS-wide ripple-carry adder
// Ports: a, b (BITS) operands; ci carry-in; s (BITS) sum; co carry-out of the top bit.
module rca_nbits #(
    parameter int BITS = 16
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            ci,
    output logic [BITS-1:0] s,
    output logic            co
);
    logic [BITS:0] c;
    assign c[0] = ci;
    for (genvar i = 0; i < BITS; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign co = c[BITS];
endmodule

// File: rtl/rca_seq_adder.sv
// rca_seq_adder: WIDTH-bit adder time-multiplexing one CHUNK-bit ripple adder, LSB chunk first
// Ports: clk rising-edge clock; rst_n async active-low reset;
// io (rca_seq_adder_if.slave): in_valid/in_ready/a/b/ci accept operands in IDLE,
// out_valid/out_ready/sum/co present the result in DONE.
// Optional: RCA_SEQ_OVF_EN adds a registered signed-overflow flag io.ovf.
// Latency: out_valid rises WIDTH/CHUNK edges after the accepting edge.
module rca_seq_adder
    import rca_seq_adder_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input logic clk,
    input logic rst_n,
    rca_seq_adder_if.slave io
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = cnt_w(N);
    if (!legal(WIDTH, CHUNK)) begin : g_bad_params
        $error("rca_seq_adder: WIDTH must be a non-zero multiple of CHUNK");
    end
    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   a_sr, b_sr, sum_r;
    logic               carry, co_r;
    logic [CHUNK-1:0]   s_chunk;
    logic               c_chunk;
    logic [WIDTH+CHUNK-1:0] sum_cat;
    logic [WIDTH-1:0]   sum_sh;
    logic               last;
    rca_nbits #(.BITS(CHUNK)) u_add (
        .a  (a_sr[CHUNK-1:0]),
        .b  (b_sr[CHUNK-1:0]),
        .ci (carry),
        .s  (s_chunk),
        .co (c_chunk)
    );
    // New chunk enters at the top; after N shifts chunk 0 sits at the bottom.
    assign sum_cat = {s_chunk, sum_r};
    assign sum_sh  = sum_cat[WIDTH+CHUNK-1:CHUNK];
    assign last    = cnt == CW'(N - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    // Unused encodings fall through to IDLE.
    always_comb begin
        state_nx     = IDLE;
        io.in_ready  = state == IDLE;
        io.out_valid = state == DONE;
        state_nx     = state == IDLE ? (io.in_valid  ? RUN  : IDLE) :
                       state == RUN  ? (last         ? DONE : RUN)  :
                       state == DONE ? (io.out_ready ? IDLE : DONE) : IDLE;
    end
`ifdef RCA_SEQ_OVF_EN
    logic a_msb, b_msb, ovf_r;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf_r <= 1'b0;
        end else if (state == IDLE && io.in_valid) begin
            a_msb <= io.a[WIDTH-1];
            b_msb <= io.b[WIDTH-1];
        end else if (state == RUN && last) begin
            ovf_r <= (a_msb == b_msb) && (sum_sh[WIDTH-1] != a_msb);
        end
    end
    assign io.ovf = ovf_r;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            sum_r <= '0;
            carry <= 1'b0;
            co_r  <= 1'b0;
            cnt   <= '0;
        end else if (state == IDLE && io.in_valid) begin
            a_sr  <= io.a;
            b_sr  <= io.b;
            carry <= io.ci;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr  <= a_sr >> CHUNK;
            b_sr  <= b_sr >> CHUNK;
            sum_r <= sum_sh;
            carry <= c_chunk;
            cnt   <= cnt + 1'b1;
            if (last) co_r <= c_chunk;
        end
    end
    assign io.sum = sum_r;
    assign io.co  = co_r;
endmodule

// File: tb/tb_rca_seq_adder.sv
// tb_rca_seq_adder: directed self-checking bench for rca_seq_adder (WIDTH=64, CHUNK=16)
module tb_rca_seq_adder;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    rca_seq_adder_if #(.WIDTH(64)) bus ();
    rca_seq_adder #(.WIDTH(64), .CHUNK(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    // Offer one operand set, return edges from accept to out_valid (-1 on timeout).
    task automatic run_op(input logic [63:0] av, input logic [63:0] bv, input logic cv, output int lat);
        @(negedge clk);
        bus.a = av;
        bus.b = bv;
        bus.ci = cv;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
    endtask
    task automatic release_op();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.ci = 1'b0;
        #12;
        checks += 4;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        if (bus.sum !== 64'h0) begin errors++; $display("FAIL reset_sum got %h want 0", bus.sum); end
        if (bus.co !== 1'b0) begin errors++; $display("FAIL reset_co got %b want 0", bus.co); end
`ifdef RCA_SEQ_OVF_EN
        checks++;
        if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    task automatic test_wrap();
        int lat;
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
        checks += 3;
        if (lat !== 4) begin errors++; $display("FAIL wrap_latency got %0d want 4", lat); end
        if (bus.sum !== 64'h0) begin errors++; $display("FAIL wrap_sum got %h want 0", bus.sum); end
        if (bus.co !== 1'b1) begin errors++; $display("FAIL wrap_co got %b want 1", bus.co); end
`ifdef RCA_SEQ_OVF_EN
        checks++;
        if (bus.ovf !== 1'b0) begin errors++; $display("FAIL wrap_ovf got %b want 0", bus.ovf); end
`endif
        release_op();
    endtask
    task automatic test_carry_chain();
        int lat;
        run_op(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b1, lat);
        checks += 3;
        if (lat !== 4) begin errors++; $display("FAIL chain_latency got %0d want 4", lat); end
        if (bus.sum !== 64'h0001_0000_0001_0001) begin errors++; $display("FAIL chain_sum got %h want 0001000000010001", bus.sum); end
        if (bus.co !== 1'b0) begin errors++; $display("FAIL chain_co got %b want 0", bus.co); end
        release_op();
    endtask
    task automatic test_signed_overflow();
        int lat;
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
        checks += 2;
        if (bus.sum !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL ovf1_sum got %h want 8000000000000000", bus.sum); end
        if (bus.co !== 1'b0) begin errors++; $display("FAIL ovf1_co got %b want 0", bus.co); end
`ifdef RCA_SEQ_OVF_EN
        checks++;
        if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf1_ovf got %b want 1", bus.ovf); end
`endif
        release_op();
        run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, lat);
        checks += 2;
        if (bus.sum !== 64'h0) begin errors++; $display("FAIL ovf2_sum got %h want 0", bus.sum); end
        if (bus.co !== 1'b1) begin errors++; $display("FAIL ovf2_co got %b want 1", bus.co); end
`ifdef RCA_SEQ_OVF_EN
        checks++;
        if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf2_ovf got %b want 1", bus.ovf); end
`endif
        release_op();
    endtask
    task automatic test_backpressure();
        int lat;
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1'b0, lat);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL bp_latency got %0d want 4", lat); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks += 4;
            if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc %0d got %b want 1", i, bus.out_valid); end
            if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b want 0", i, bus.in_ready); end
            if (bus.sum !== 64'hF) begin errors++; $display("FAIL bp_sum cyc %0d got %h want f", i, bus.sum); end
            if (bus.co !== 1'b1) begin errors++; $display("FAIL bp_co cyc %0d got %b want 1", i, bus.co); end
            bus.in_valid = i < 5;
            bus.a = 64'd100 + 64'(i);
            bus.b = 64'd200;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks += 3;
            if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_in_ready cyc %0d got %b want 1", i, bus.in_ready); end
            if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle_out_valid cyc %0d got %b want 0", i, bus.out_valid); end
            if (bus.sum !== 64'hF) begin errors++; $display("FAIL bp_idle_sum cyc %0d got %h want f", i, bus.sum); end
        end
    endtask
    task automatic test_reset_mid_run();
        int lat;
        @(negedge clk);
        bus.a = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.b = 64'h1234_5678_9ABC_DEF0;
        bus.ci = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", bus.out_valid); end
        if (bus.sum !== 64'h0) begin errors++; $display("FAIL midrst_sum got %h want 0", bus.sum); end
        if (bus.co !== 1'b0) begin errors++; $display("FAIL midrst_co got %b want 0", bus.co); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", bus.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL postrst_in_ready got %b want 1", bus.in_ready); end
        run_op(64'd3, 64'd4, 1'b0, lat);
        checks += 3;
        if (lat !== 4) begin errors++; $display("FAIL postrst_latency got %0d want 4", lat); end
        if (bus.sum !== 64'd7) begin errors++; $display("FAIL postrst_sum got %h want 7", bus.sum); end
        if (bus.co !== 1'b0) begin errors++; $display("FAIL postrst_co got %b want 0", bus.co); end
        release_op();
    endtask
    task automatic test_back_to_back();
        logic [63:0] av [3];
        logic [63:0] bv [3];
        logic        cv [3];
        logic [64:0] exp_r [3];
        int          acc_k [3];
        int          acc, res;
        for (int i = 0; i < 3; i++) begin
            av[i] = {$urandom, $urandom};
            bv[i] = {$urandom, $urandom};
            cv[i] = 1'($urandom_range(0, 1));
            exp_r[i] = {1'b0, av[i]} + {1'b0, bv[i]} + 65'(cv[i]);
        end
        acc = 0;
        res = 0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 60 && res < 3; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                checks += 2;
                if (bus.sum !== exp_r[res][63:0]) begin errors++; $display("FAIL b2b_sum op %0d got %h want %h", res, bus.sum, exp_r[res][63:0]); end
                if (bus.co !== exp_r[res][64]) begin errors++; $display("FAIL b2b_co op %0d got %b want %b", res, bus.co, exp_r[res][64]); end
                res++;
            end
            if (bus.in_ready && acc < 3) begin
                bus.a = av[acc];
                bus.b = bv[acc];
                bus.ci = cv[acc];
                bus.in_valid = 1'b1;
                acc_k[acc] = k;
                acc++;
            end else if (acc >= 3) begin
                bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        checks += 3;
        if (res !== 3) begin errors++; $display("FAIL b2b_results got %0d want 3", res); end
        if (acc_k[1] - acc_k[0] !== 6) begin errors++; $display("FAIL b2b_gap01 got %0d want 6", acc_k[1] - acc_k[0]); end
        if (acc_k[2] - acc_k[1] !== 6) begin errors++; $display("FAIL b2b_gap12 got %0d want 6", acc_k[2] - acc_k[1]); end
    endtask
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_wrap();
        test_carry_chain();
        test_signed_overflow();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
